// File: rtl/vga_pkg.sv
// Shared types and AXI constants for the VGA frame-buffer burst fetcher.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARREQ = 2'd1,
        RDATA = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_PROT_DEF   = 3'b001;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/vga_sync_fifo.sv
// Synchronous FIFO with show-ahead head word, occupancy count and a synchronous flush.
module vga_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;

    // A pop frees a slot in the same cycle, so push on full is accepted when paired with a pop.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/vga_axi_burst_fetch.sv
// AXI4 INCR-burst read master prefetching frame-buffer words into a FIFO for the pixel pipeline.
module vga_axi_burst_fetch #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        BURST_LEN      = 8,
    parameter int                        FIFO_DEPTH     = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] FB_BASE_ADDR   = '0,
    parameter int                        FRAME_WORDS    = 38400
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic                        frame_start_i,
    output logic [AXI_DATA_WIDTH-1:0]   pxl_data_o,
    output logic                        pxl_valid_o,
    input  logic                        pxl_rdy_i,
    output logic                        underflow_o,
    output logic                        err_o,
    output logic [AXI_ADDR_WIDTH-1:0]   m_araddr_o,
    output logic [7:0]                  m_arlen_o,
    output logic [2:0]                  m_arsize_o,
    output logic [1:0]                  m_arburst_o,
    output logic [2:0]                  m_arprot_o,
    output logic                        m_arvalid_o,
    input  logic                        m_arrdy_i,
    input  logic [AXI_DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]                  m_rresp_i,
    input  logic                        m_rlast_i,
    input  logic                        m_rvalid_i,
    output logic                        m_rrdy_o
);
    import vga_pkg::*;

    localparam int         BURST_BYTES = BURST_LEN * AXI_DATA_WIDTH / 8;
    localparam int         CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int         WW          = $clog2(FRAME_WORDS + 1);
    localparam logic [8:0] LAST_BEAT   = 9'(BURST_LEN - 1);

    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
        $error("BURST_LEN must lie in 1..256");
    end
    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2 * BURST_LEN) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of two and at least 2*BURST_LEN");
    end
    if (!is_pow2(AXI_DATA_WIDTH) || AXI_DATA_WIDTH < 8) begin : g_bad_data_width
        $error("AXI_DATA_WIDTH must be a power of two of at least 8");
    end
    if (BURST_BYTES > 4096 || (FB_BASE_ADDR % AXI_ADDR_WIDTH'(BURST_BYTES)) != '0) begin : g_bad_base
        $error("FB_BASE_ADDR must be burst aligned and a burst must fit in 4 KB");
    end
    if (FRAME_WORDS < BURST_LEN || (FRAME_WORDS % BURST_LEN) != 0) begin : g_bad_frame
        $error("FRAME_WORDS must be a non-zero multiple of BURST_LEN");
    end

    fetch_state_t              state_q;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [WW-1:0]             words_q;
    logic [8:0]                beat_q;
    logic                      arvalid_q;
    logic                      rrdy_q;
    logic                      restart_pend_q;
    logic                      err_q;
    logic                      err_d;

    logic                      ar_hs;
    logic                      r_hs;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_flush;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [CW-1:0]             free_slots;
    logic                      can_issue;

    assign ar_hs = arvalid_q & m_arrdy_i;
    assign r_hs  = m_rvalid_i & rrdy_q;

    // In IDLE no beats are outstanding, so every unfilled entry is unreserved.
    assign free_slots = CW'(FIFO_DEPTH) - fifo_count;
    assign can_issue  = en_i && (free_slots >= CW'(BURST_LEN)) && (words_q < WW'(FRAME_WORDS));

    // The beat that coincides with frame_start_i belongs to the abandoned frame.
    assign fifo_push  = r_hs && (state_q == RDATA) && !frame_start_i;
    assign fifo_pop   = pxl_rdy_i & ~fifo_empty;
    assign fifo_flush = ((state_q == IDLE)  && frame_start_i)
                     || ((state_q == RDATA) && frame_start_i && r_hs && m_rlast_i)
                     || ((state_q == DRAIN) && r_hs && m_rlast_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            araddr_q       <= FB_BASE_ADDR;
            words_q        <= '0;
            beat_q         <= '0;
            arvalid_q      <= 1'b0;
            rrdy_q         <= 1'b0;
            restart_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start_i) begin
                        araddr_q <= FB_BASE_ADDR;
                        words_q  <= '0;
                    end else if (can_issue) begin
                        state_q   <= ARREQ;
                        arvalid_q <= 1'b1;
                    end
                end
                ARREQ: begin
                    // The address phase cannot be withdrawn, so a restart waits for the handshake.
                    if (frame_start_i) begin
                        restart_pend_q <= 1'b1;
                    end
                    if (ar_hs) begin
                        arvalid_q      <= 1'b0;
                        rrdy_q         <= 1'b1;
                        beat_q         <= '0;
                        restart_pend_q <= 1'b0;
                        state_q        <= (restart_pend_q || frame_start_i) ? DRAIN : RDATA;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        beat_q <= beat_q + 9'd1;
                    end
                    if (r_hs && m_rlast_i) begin
                        rrdy_q  <= 1'b0;
                        state_q <= IDLE;
                        if (frame_start_i) begin
                            araddr_q <= FB_BASE_ADDR;
                            words_q  <= '0;
                        end else begin
                            araddr_q <= araddr_q + AXI_ADDR_WIDTH'(BURST_BYTES);
                            words_q  <= words_q + WW'(BURST_LEN);
                        end
                    end else if (frame_start_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_hs) begin
                        beat_q <= beat_q + 9'd1;
                    end
                    if (r_hs && m_rlast_i) begin
                        rrdy_q   <= 1'b0;
                        state_q  <= IDLE;
                        araddr_q <= FB_BASE_ADDR;
                        words_q  <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                    rrdy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Error responses of a frame being abandoned are not reported.
    always_comb begin
        err_d = err_q;
        if (frame_start_i) begin
            err_d = 1'b0;
        end else if (r_hs && (state_q == RDATA) && (m_rresp_i != AXI_RESP_OKAY)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    vga_sync_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (m_rdata_i),
        .pop_i   (fifo_pop),
        .data_o  (pxl_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign pxl_valid_o = ~fifo_empty;
    assign underflow_o = pxl_rdy_i & fifo_empty;
    assign err_o       = err_q;

    assign m_araddr_o  = araddr_q;
    assign m_arlen_o   = 8'(BURST_LEN - 1);
    assign m_arsize_o  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign m_arburst_o = AXI_BURST_INCR;
    assign m_arprot_o  = AXI_PROT_DEF;
    assign m_arvalid_o = arvalid_q;
    assign m_rrdy_o    = rrdy_q;

    a_rlast_matches_len: assert property (@(posedge clk) disable iff (!rst_n)
        r_hs |-> (m_rlast_i == (beat_q == LAST_BEAT)));

    a_fifo_never_overflows: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_vga_axi_burst_fetch.sv
// Directed-plus-random bench: AXI slave responder, in-order word scoreboard, frame restart and error cases.
module tb_vga_axi_burst_fetch;
    localparam int BL = 8;
    localparam int FW = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        frame_start_i;
    logic [63:0] pxl_data_o;
    logic        pxl_valid_o;
    logic        pxl_rdy_i;
    logic        underflow_o;
    logic        err_o;
    logic [31:0] m_araddr_o;
    logic [7:0]  m_arlen_o;
    logic [2:0]  m_arsize_o;
    logic [1:0]  m_arburst_o;
    logic [2:0]  m_arprot_o;
    logic        m_arvalid_o;
    logic        m_arrdy_i;
    logic [63:0] m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic        m_rlast_i;
    logic        m_rvalid_i;
    logic        m_rrdy_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_word = '0;
    int          pop_budget = 0;
    int          uf_cnt = 0;
    logic [31:0] ar_q[$];
    bit          s_rand = 1'b0;
    int          s_delay = 0;
    logic [63:0] s_err_word = '1;
    logic [31:0] s_cur_addr = '1;
    int          s_cur_beat = -1;

    vga_axi_burst_fetch #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (64),
        .BURST_LEN      (BL),
        .FIFO_DEPTH     (32),
        .FB_BASE_ADDR   (32'h0),
        .FRAME_WORDS    (FW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en_i),
        .frame_start_i (frame_start_i),
        .pxl_data_o    (pxl_data_o),
        .pxl_valid_o   (pxl_valid_o),
        .pxl_rdy_i     (pxl_rdy_i),
        .underflow_o   (underflow_o),
        .err_o         (err_o),
        .m_araddr_o    (m_araddr_o),
        .m_arlen_o     (m_arlen_o),
        .m_arsize_o    (m_arsize_o),
        .m_arburst_o   (m_arburst_o),
        .m_arprot_o    (m_arprot_o),
        .m_arvalid_o   (m_arvalid_o),
        .m_arrdy_i     (m_arrdy_i),
        .m_rdata_i     (m_rdata_i),
        .m_rresp_i     (m_rresp_i),
        .m_rlast_i     (m_rlast_i),
        .m_rvalid_i    (m_rvalid_i),
        .m_rrdy_o      (m_rrdy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ar(input int n, input int max_cyc);
        for (int c = 0; c < max_cyc && ar_q.size() < n; c++) tick();
        check("ar_count_reached", 64'(ar_q.size()), 64'(n));
    endtask

    task automatic consume(input int n, input bit rnd, input int max_cyc);
        pop_budget = n;
        for (int c = 0; c < max_cyc && pop_budget > 0; c++) begin
            pxl_rdy_i = rnd ? 1'($urandom_range(1)) : 1'b1;
            tick();
        end
        pxl_rdy_i = 1'b0;
        check("consume_done", 64'(pop_budget), 64'd0);
    endtask

    task automatic pulse_frame_start();
        exp_word      = '0;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    // Scoreboard: each frame delivers word indices 0,1,2,... in order.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pxl_valid_o && pxl_rdy_i) begin
                check("pop_data", pxl_data_o, exp_word);
                exp_word = exp_word + 64'd1;
                if (pop_budget > 0) pop_budget--;
            end
            if (underflow_o) uf_cnt++;
        end
    end

    // AXI slave: beat b of a burst at address A carries word index A/8 + b.
    initial begin : slave
        int          dly;
        int          gap;
        logic [31:0] a0;
        logic [63:0] w;
        bit          acc;
        m_arrdy_i  = 1'b0;
        m_rvalid_i = 1'b0;
        m_rlast_i  = 1'b0;
        m_rdata_i  = '0;
        m_rresp_i  = 2'b00;
        wait (rst_n === 1'b1);
        forever begin
            do begin @(posedge clk); #1; end while (!m_arvalid_o);
            a0  = m_araddr_o;
            dly = s_rand ? int'($urandom_range(5)) : s_delay;
            gap = s_rand ? 30 : 0;
            for (int i = 0; i < dly; i++) begin
                @(posedge clk); #1;
                check("ar_valid_stable", 64'(m_arvalid_o), 64'd1);
                check("ar_addr_stable", 64'(m_araddr_o), 64'(a0));
            end
            m_arrdy_i = 1'b1;
            @(posedge clk); #1;
            m_arrdy_i = 1'b0;
            ar_q.push_back(a0);
            $display("AR #%0d addr=%h delay=%0d", ar_q.size() - 1, a0, dly);
            s_cur_addr = a0;
            for (int b = 0; b < BL; b++) begin
                w = 64'(a0 >> 3) + 64'(b);
                while (int'($urandom_range(99)) < gap) begin
                    m_rvalid_i = 1'b0;
                    @(posedge clk); #1;
                end
                m_rvalid_i = 1'b1;
                m_rdata_i  = w;
                m_rlast_i  = (b == BL - 1);
                m_rresp_i  = (w == s_err_word) ? 2'b10 : 2'b00;
                s_cur_beat = b;
                do begin
                    acc = m_rrdy_o;
                    if (acc && w == s_err_word) check("err_before_bad_beat", 64'(err_o), 64'd0);
                    @(posedge clk); #1;
                end while (!acc);
                if (w == s_err_word) check("err_after_bad_beat", 64'(err_o), 64'd1);
            end
            m_rvalid_i = 1'b0;
            m_rlast_i  = 1'b0;
            m_rresp_i  = 2'b00;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base_n;
        rst_n         = 1'b0;
        en_i          = 1'b0;
        frame_start_i = 1'b0;
        pxl_rdy_i     = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Reset state and constant AR attributes.
        check("rst_arvalid", 64'(m_arvalid_o), 64'd0);
        check("rst_rrdy", 64'(m_rrdy_o), 64'd0);
        check("rst_araddr", 64'(m_araddr_o), 64'h0);
        check("rst_pxl_valid", 64'(pxl_valid_o), 64'd0);
        check("rst_pxl_data", pxl_data_o, 64'd0);
        check("rst_underflow", 64'(underflow_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("arlen", 64'(m_arlen_o), 64'd7);
        check("arsize", 64'(m_arsize_o), 64'd3);
        check("arburst", 64'(m_arburst_o), 64'd1);
        check("arprot", 64'(m_arprot_o), 64'd1);

        // Popping an empty FIFO pulses underflow every cycle.
        pxl_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("uf_pulse", 64'(underflow_o), 64'd1);
            check("uf_valid_low", 64'(pxl_valid_o), 64'd0);
            tick();
        end
        pxl_rdy_i = 1'b0;
        @(negedge clk);
        check("uf_clear", 64'(underflow_o), 64'd0);
        tick();

        // Fill: four bursts reach 32 words, then fetching waits for 8 free slots.
        en_i    = 1'b1;
        s_delay = 0;
        wait_ar(4, 200);
        repeat (60) tick();
        check("fill_ar_count", 64'(ar_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("fill_ar_addr", 64'(ar_q[i]), 64'(32'h40 * i));
        check("fill_valid", 64'(pxl_valid_o), 64'd1);
        check("fill_head", pxl_data_o, 64'd0);
        consume(7, 1'b0, 50);
        repeat (20) tick();
        check("seven_pops_no_ar", 64'(ar_q.size()), 64'd4);
        consume(1, 1'b0, 10);
        wait_ar(5, 50);
        check("eighth_pop_ar_addr", 64'(ar_q[4]), 64'h100);

        // Continuous consumer drains the rest of the frame without underflow.
        uf_cnt = 0;
        consume(FW - 8, 1'b0, 1000);
        check("frame_words", exp_word, 64'(FW));
        check("frame_no_underflow", 64'(uf_cnt), 64'd0);
        repeat (40) tick();
        check("frame_end_no_ar", 64'(ar_q.size()), 64'd8);
        check("frame_end_empty", 64'(pxl_valid_o), 64'd0);

        // Delayed AR ready, then a fully randomised frame.
        s_delay = 5;
        pulse_frame_start();
        wait_ar(9, 100);
        check("delayed_ar_addr", 64'(ar_q[8]), 64'h0);
        s_rand = 1'b1;
        consume(FW, 1'b1, 4000);
        repeat (60) tick();
        check("rand_frame_ar_count", 64'(ar_q.size()), 64'd16);
        check("rand_frame_err", 64'(err_o), 64'd0);

        // Restart in the middle of the burst at 0x80.
        s_rand  = 1'b0;
        s_delay = 0;
        pulse_frame_start();
        for (int c = 0; c < 300 && !(s_cur_addr == 32'h80 && s_cur_beat == 3 && m_rvalid_i); c++) tick();
        check("beat3_at_0x80_seen", 64'(s_cur_addr), 64'h80);
        check("pre_restart_valid", 64'(pxl_valid_o), 64'd1);
        base_n = ar_q.size();
        pulse_frame_start();
        wait_ar(base_n + 1, 100);
        check("restart_ar_addr", 64'(ar_q[base_n]), 64'h0);
        check("restart_fifo_empty", 64'(pxl_valid_o), 64'd0);
        consume(FW, 1'b0, 1500);

        // Error response on word 20: data still delivered, err sticky until frame start.
        s_rand     = 1'b1;
        s_err_word = 64'd20;
        pulse_frame_start();
        check("err_clear_at_start", 64'(err_o), 64'd0);
        consume(FW, 1'b1, 4000);
        check("err_set", 64'(err_o), 64'd1);
        s_err_word = '1;
        s_rand     = 1'b0;
        repeat (20) tick();
        check("err_sticky", 64'(err_o), 64'd1);

        // Frame start clears err; dropping en_i mid-burst lets that burst finish only.
        base_n = ar_q.size();
        pulse_frame_start();
        check("err_cleared", 64'(err_o), 64'd0);
        for (int c = 0; c < 200 && !(ar_q.size() == base_n + 1 && s_cur_beat == 2 && m_rvalid_i); c++) tick();
        en_i = 1'b0;
        repeat (50) tick();
        check("en_low_single_burst", 64'(ar_q.size()), 64'(base_n + 1));
        check("en_low_burst_done", 64'(pxl_valid_o), 64'd1);
        check("en_low_head", pxl_data_o, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
